// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// alignment rule applied to every accepted request.
package lsu_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RMW   = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    // Size 2'b11 has no encoding and is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends a loaded lane, and merges store
// data into the current memory word for partial writes.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rd_word,
    input  logic [1:0]            size,
    input  logic [1:0]            offset,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] merge_data
);

    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    always_comb begin
        byte_v     = rd_word[{offset, 3'b000} +: BYTE_W];
        half_v     = rd_word[{offset[1], 4'b0000} +: HALF_W];
        load_data  = rd_word;
        merge_data = rd_word;
        case (size)
            SZ_BYTE: begin
                load_data = {{(DATA_WIDTH-BYTE_W){~is_unsigned & byte_v[BYTE_W-1]}}, byte_v};
                merge_data[{offset, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_data = {{(DATA_WIDTH-HALF_W){~is_unsigned & half_v[HALF_W-1]}}, half_v};
                merge_data[{offset[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            end
            SZ_WORD: begin
                merge_data = wdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-wide memory with
// combinational read; sub-word stores go through a read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0]    mem_WD,
    output logic                     mem_WE,
    input  logic [DATA_WIDTH-1:0]    mem_RD
);

    lsu_state_e               state_q, state_d;
    logic                     ready_q, ready_d;
    logic                     resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     we_q, we_d;
    logic                     store_q, store_d;
    logic [1:0]               size_q, size_d;
    logic                     uns_q, uns_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    merge_q, merge_d;
    logic [DATA_WIDTH-1:0]    load_data;
    logic [DATA_WIDTH-1:0]    merge_data;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .rd_word     (mem_RD),
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            store_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            we_q         <= we_d;
            store_q      <= store_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_size == SZ_WORD) begin
                        merge_d = req_wdata;
                        state_d = WRITE;
                    end else begin
                        state_d = RMW;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_data;
                state_d = RESP;
            end
            RMW: begin
                merge_d = merge_data;
                state_d = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Response fields change only on entry to RESP and then hold.
        if (state_d == RESP) begin
            err_d = (state_q == IDLE);
            if (state_q != LOAD) begin
                rdata_d = '0;
            end
        end

        ready_d      = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        we_d         = (state_d == WRITE);
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_WE     = we_q;
    assign mem_WD     = merge_q;
    assign mem_A      = addr_q >> 2;

    logic unused_store;
    assign unused_store = store_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a 256-word behavioural memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_WE;
    logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;

    logic [31:0] mem [0:255];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          hs;
        int          lat;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    exp_t rq[$];
    wr_t  wq[$];

    load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_A        (mem_A),
        .mem_WD       (mem_WD),
        .mem_WE       (mem_WE),
        .mem_RD       (mem_RD)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_RD = mem[mem_A[7:0]];
    always @(posedge clk) if (mem_WE) mem[mem_A[7:0]] <= mem_WD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    // Response and write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (rq.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = rq.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("resp_latency", 32'(cyc - e.hs), 32'(e.lat));
                check("ready_in_resp", 32'(req_ready), 32'd0);
            end
        end
        if (!rst && mem_WE) begin
            if (wq.size() == 0) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("mem_A", mem_A, w.a);
                check("mem_WD", mem_WD, w.d);
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] erd, input logic eerr, input int elat,
                          input logic push, input logic push_wr, input logic [31:0] ewd,
                          output int hs);
        int n;
        exp_t e;
        wr_t w;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
        hs = cyc;
        if (push) begin
            e.rdata = erd; e.err = eerr; e.hs = hs; e.lat = elat;
            rq.push_back(e);
        end
        if (push_wr) begin
            w.a = addr >> 2; w.d = ewd;
            wq.push_back(w);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(rq.size() + wq.size()), 32'd0);
    endtask

    initial begin
        int hs, hs2;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h01] = 32'h01010101;
        mem[8'h10] = 32'h8899AABB;
        mem[8'h11] = 32'h11223344;
        mem[8'h12] = 32'hCAFEF00D;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_WE", 32'(mem_WE), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        // Loads over word 0x10 = 0x8899AABB and word 0x11.
        do_req(0, 2'b00, 0, 32'h41, 0, 32'hFFFFFFAA, 0, 2, 1, 0, 0, hs);
        do_req(0, 2'b01, 1, 32'h42, 0, 32'h00008899, 0, 2, 1, 0, 0, hs);
        do_req(0, 2'b01, 0, 32'h42, 0, 32'hFFFF8899, 0, 2, 1, 0, 0, hs);
        do_req(0, 2'b00, 1, 32'h40, 0, 32'h000000BB, 0, 2, 1, 0, 0, hs);
        do_req(0, 2'b10, 0, 32'h44, 0, 32'h11223344, 0, 2, 1, 0, 0, hs);
        drain();
        repeat (2) @(negedge clk);
        check("hold_rdata", resp_rdata, 32'h11223344);
        check("hold_err", 32'(resp_err), 32'd0);

        // Sub-word stores and misaligned/illegal requests.
        do_req(1, 2'b00, 0, 32'h43, 32'h5A, 32'h0, 0, 3, 1, 1, 32'h5A99AABB, hs);
        do_req(1, 2'b10, 0, 32'h06, 32'h12345678, 32'h0, 1, 1, 1, 0, 0, hs);
        do_req(0, 2'b01, 0, 32'h45, 0, 32'h0, 1, 1, 1, 0, 0, hs);
        do_req(0, 2'b11, 0, 32'h40, 0, 32'h0, 1, 1, 1, 0, 0, hs);
        do_req(1, 2'b01, 0, 32'h4A, 32'h1234BEEF, 32'h0, 0, 3, 1, 1, 32'hBEEFF00D, hs);
        drain();
        check("hold_err_after_store", 32'(resp_err), 32'd0);

        // Reset during the RMW cycle of a half store aborts it silently.
        do_req(1, 2'b01, 0, 32'h44, 32'h7777, 32'h0, 0, 3, 0, 0, 0, hs);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);
        check("rdata_after_rst", resp_rdata, 32'd0);
        repeat (6) @(negedge clk);

        // Word store then immediate load of the same word.
        do_req(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 32'h0, 0, 2, 1, 1, 32'hDEADBEEF, hs);
        do_req(0, 2'b10, 0, 32'h20, 0, 32'hDEADBEEF, 0, 2, 1, 0, 0, hs2);
        check("b2b_handshake_gap", 32'(hs2 - hs), 32'd3);
        drain();

        check("mem_10", mem[8'h10], 32'h5A99AABB);
        check("mem_01_untouched", mem[8'h01], 32'h01010101);
        check("mem_11_untouched", mem[8'h11], 32'h11223344);
        check("mem_12", mem[8'h12], 32'hBEEFF00D);
        check("mem_08", mem[8'h08], 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: width of the byte address and the memory word index.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of the data word (fixed at 4 byte lanes).
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: pipeline request present.
REQ-006 SHALL have port req_ready, output, 1: unit accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 SHALL have port req_unsigned, input, 1: zero-extend the load result (1) or sign-extend it (0).
REQ-010 SHALL have port req_addr, input, ADDRESS_WIDTH: byte address.
REQ-011 SHALL have port req_wdata, input, DATA_WIDTH: store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1: single-cycle completion pulse.
REQ-013 SHALL have port resp_rdata, output, DATA_WIDTH: extended load data; 0 for stores.
REQ-014 SHALL have port resp_err, output, 1: misaligned or illegal-size request; valid with resp_valid.
REQ-015 SHALL have port mem_A, output, ADDRESS_WIDTH: word index = captured req_addr >> 2.
REQ-016 SHALL have port mem_WD, output, DATA_WIDTH: full-word write data.
REQ-017 SHALL have port mem_WE, output, 1: memory write enable.
REQ-018 SHALL have port mem_RD, input, DATA_WIDTH: combinational read data for mem_A.

Function
REQ-019 SHALL implement the FSM states IDLE, LOAD, RMW, WRITE and RESP.
REQ-020 SHALL drive req_ready = 1 only in IDLE; a handshake (req_valid & req_ready) captures all req_* fields into registers.
REQ-021 On handshake, SHALL flag misalignment when: size 01 with addr[0] = 1; size 10 with addr[1:0] != 0; or size 11. A misaligned request SHALL go to RESP with resp_err = 1, make no memory access and never assert mem_WE.
REQ-022 Aligned loads SHALL go IDLE -> LOAD -> RESP. In LOAD, the unit SHALL extract the lane selected by addr[1:0] from mem_RD, extend it per req_unsigned and register it.
REQ-023 Aligned word stores SHALL go IDLE -> WRITE -> RESP.
REQ-024 Aligned byte and half stores SHALL go IDLE -> RMW -> WRITE -> RESP. RMW SHALL register mem_RD with the target lanes replaced by req_wdata[7:0] or req_wdata[15:0]; other lanes SHALL be unchanged.
REQ-025 SHALL assert mem_WE only in WRITE, for exactly one cycle per store, with mem_WD taken from the merge register.
REQ-026 SHALL assert resp_valid only in RESP, for one cycle; the next state SHALL be IDLE. There is no response backpressure.
REQ-027 Latency from handshake cycle to resp_valid cycle SHALL be: misaligned 1, load 2, word store 2, sub-word store 3.
REQ-028 Back-to-back requests SHALL be accepted in the cycle after RESP at the earliest.
REQ-029 resp_rdata and resp_err SHALL hold their values until the next RESP.

Reset
REQ-030 While rst = 1, SHALL force: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, mem_WE 0, all capture and merge registers 0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no further mem_WE and no resp_valid; req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 Package lsu_pkg SHALL hold the size enum (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-033 A combinational sub-module lsu_align SHALL perform lane extraction with extension and lane merge; the FSM and registers SHALL live in load_store_unit.

Verification
REQ-034 Memory word 0x10 holds 0x8899AABB; load byte, addr 0x41, signed -> resp_rdata 0xFFFFFFAA, 2 cycles, resp_err 0.
REQ-035 Same word; load half, addr 0x42, unsigned -> resp_rdata 0x00008899.
REQ-036 Store byte 0x5A to addr 0x43 over 0x8899AABB -> one mem_WE pulse, mem_A 0x10, mem_WD 0x5A99AABB, resp_valid 3 cycles after handshake.
REQ-037 Store word, addr 0x06 -> resp_err 1 after 1 cycle, mem_WE never asserted, memory unchanged.
REQ-038 Assert rst in the RMW cycle of a half store -> no mem_WE, no resp_valid, req_ready 1 after release, memory unchanged.
REQ-039 Word store 0xDEADBEEF to 0x20, then an immediate load word from 0x20 -> 0xDEADBEEF, with the second handshake in the cycle after the first RESP.
